// File: rtl/ce_strobe_gen_if.sv
// ce_strobe_gen_if: control and status bundle for ce_strobe_gen.
//   master modport : driven by the controller / testbench
//   slave modport  : seen by ce_strobe_gen
// Signals:
//   run     - 1 = free-run strobes, 0 = paused
//   step    - debounced level, each rising edge requests one strobe while paused
//   div_ld  - load divide ratio from div_d
//   div_d   - new divide ratio N
//   fast    - fast-mode request (only honoured with CE_STROBE_FAST_EN)
//   ce_out  - registered one-cycle enable strobe
//   running - registered, 1 while in the running state
//   phase   - current prescale count
interface ce_strobe_gen_if #(
   parameter int unsigned DIV_WIDTH = 24
);
   logic                 run;
   logic                 step;
   logic                 div_ld;
   logic [DIV_WIDTH-1:0] div_d;
   logic                 fast;
   logic                 ce_out;
   logic                 running;
   logic [DIV_WIDTH-1:0] phase;

   modport master (
      output run, step, div_ld, div_d, fast,
      input  ce_out, running, phase
   );

   modport slave (
      input  run, step, div_ld, div_d, fast,
      output ce_out, running, phase
   );
endinterface

// File: rtl/ce_strobe_gen.sv
// ce_strobe_gen: programmable clock-enable strobe generator.
// Divides clk down to a one-cycle ce_out pulse every N cycles, with run/pause
// and single-step control.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - ce_strobe_gen_if.slave (run, step, div_ld, div_d, fast in;
//          ce_out, running, phase out)
// Optional feature macro: CE_STROBE_FAST_EN -- when defined, fast=1 at a
// reload shortens the next period to max(Ne >> FAST_SHIFT, 1).
module ce_strobe_gen #(
   parameter int unsigned DIV_WIDTH   = 24,
   parameter int unsigned DEFAULT_DIV = 12000000,
   parameter int unsigned FAST_SHIFT  = 4
) (
   input logic             clk,
   input logic             rst,
   ce_strobe_gen_if.slave  bus
);

   typedef enum logic {StPaused, StRunning} state_e;

   state_e               state_q, state_d;
   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic                 ce_q, ce_d;
   logic                 step_q;

   logic [DIV_WIDTH-1:0] ne;
   logic [DIV_WIDTH-1:0] reload;
   logic                 step_edge;

   // A ratio of 0 behaves as 1 (strobe every cycle).
   assign ne        = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
   assign step_edge = bus.step & ~step_q;

`ifdef CE_STROBE_FAST_EN
   logic [DIV_WIDTH-1:0] ne_fast;

   always_comb begin
      ne_fast = ne >> FAST_SHIFT;
      if (ne_fast == '0) ne_fast = DIV_WIDTH'(1);
      reload = bus.fast ? (ne_fast - DIV_WIDTH'(1)) : (ne - DIV_WIDTH'(1));
   end
`else
   logic unused_fast;
   assign unused_fast = bus.fast;
   assign reload      = ne - DIV_WIDTH'(1);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ce_d    = 1'b0;
      if (bus.div_ld) begin
         // Load wins over state behaviour; a coincident step edge is dropped.
         cnt_d = (bus.div_d == '0) ? '0 : (bus.div_d - DIV_WIDTH'(1));
      end else begin
         unique case (state_q)
            StPaused: begin
               if (bus.run) begin
                  state_d = StRunning;
               end else if (step_edge) begin
                  ce_d  = 1'b1;
                  cnt_d = reload;
               end
            end
            StRunning: begin
               if (!bus.run) begin
                  state_d = StPaused;
               end else if (cnt_q == '0) begin
                  ce_d  = 1'b1;
                  cnt_d = reload;
               end else begin
                  cnt_d = cnt_q - DIV_WIDTH'(1);
               end
            end
            default: state_d = StPaused;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StPaused;
         div_q   <= DIV_WIDTH'(DEFAULT_DIV);
         cnt_q   <= DIV_WIDTH'(DEFAULT_DIV) - DIV_WIDTH'(1);
         ce_q    <= 1'b0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ce_q    <= ce_d;
         step_q  <= bus.step;
         if (bus.div_ld) div_q <= bus.div_d;
      end
   end

   assign bus.ce_out  = ce_q;
   assign bus.running = (state_q == StRunning);
   assign bus.phase   = cnt_q;

endmodule

// File: tb/tb_ce_strobe_gen.sv
// tb_ce_strobe_gen: directed self-checking bench for ce_strobe_gen.
module tb_ce_strobe_gen;

   logic clk;
   logic rst;
   int   passed;
   int   total;

   ce_strobe_gen_if #(.DIV_WIDTH(24)) bus ();

   ce_strobe_gen #(
      .DIV_WIDTH  (24),
      .DEFAULT_DIV(12000000),
      .FAST_SHIFT (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      total++;
      if (bus.ce_out !== 1'b0) $display("FAIL reset_ce got %0d exp 0", bus.ce_out);
      else passed++;
      total++;
      if (bus.running !== 1'b0) $display("FAIL reset_running got %0d exp 0", bus.running);
      else passed++;
      total++;
      if (bus.phase !== 24'd11999999) $display("FAIL reset_phase got %0d exp 11999999", bus.phase);
      else passed++;
   endtask

   // Load N=4 then run; strobes after E+4, E+8, E+12.
   task automatic test_run_period();
      bus.div_ld = 1'b1;
      bus.div_d  = 24'd4;
      tick();
      bus.div_ld = 1'b0;
      total++;
      if (bus.phase !== 24'd3) $display("FAIL load4_phase got %0d exp 3", bus.phase);
      else passed++;
      bus.run = 1'b1;
      tick();
      total++;
      if (bus.running !== 1'b1 || bus.ce_out !== 1'b0)
         $display("FAIL run_start got running=%0d ce=%0d exp running=1 ce=0", bus.running, bus.ce_out);
      else passed++;
      for (int i = 1; i <= 12; i++) begin
         tick();
         total++;
         if (bus.ce_out !== ((i % 4) == 0))
            $display("FAIL run_period_%0d got %0d exp %0d", i, bus.ce_out, ((i % 4) == 0));
         else passed++;
      end
   endtask

   // Continues from a strobe with cnt=3: pause mid-period then resume.
   task automatic test_pause_resume();
      tick();
      tick();
      total++;
      if (bus.phase !== 24'd1) $display("FAIL pre_pause_phase got %0d exp 1", bus.phase);
      else passed++;
      bus.run = 1'b0;
      tick();
      total++;
      if (bus.running !== 1'b0 || bus.phase !== 24'd1)
         $display("FAIL pause_enter got running=%0d phase=%0d exp running=0 phase=1", bus.running, bus.phase);
      else passed++;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (bus.ce_out !== 1'b0 || bus.phase !== 24'd1)
            $display("FAIL paused_%0d got ce=%0d phase=%0d exp ce=0 phase=1", i, bus.ce_out, bus.phase);
         else passed++;
      end
      bus.run = 1'b1;
      tick();
      total++;
      if (bus.running !== 1'b1 || bus.ce_out !== 1'b0 || bus.phase !== 24'd1)
         $display("FAIL resume got running=%0d ce=%0d phase=%0d exp 1 0 1", bus.running, bus.ce_out, bus.phase);
      else passed++;
      tick();
      total++;
      if (bus.ce_out !== 1'b0 || bus.phase !== 24'd0)
         $display("FAIL resume_1 got ce=%0d phase=%0d exp ce=0 phase=0", bus.ce_out, bus.phase);
      else passed++;
      tick();
      total++;
      if (bus.ce_out !== 1'b1 || bus.phase !== 24'd3)
         $display("FAIL resume_strobe got ce=%0d phase=%0d exp ce=1 phase=3", bus.ce_out, bus.phase);
      else passed++;
   endtask

   // Paused, N=5: step high 7 cycles, low, high again -> two strobes.
   task automatic test_step();
      int strobes;
      strobes  = 0;
      bus.run  = 1'b0;
      tick();
      bus.div_ld = 1'b1;
      bus.div_d  = 24'd5;
      tick();
      bus.div_ld = 1'b0;
      bus.step   = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         strobes += int'(bus.ce_out);
         total++;
         if (bus.ce_out !== (i == 0))
            $display("FAIL step_hold_%0d got %0d exp %0d", i, bus.ce_out, (i == 0));
         else passed++;
      end
      bus.step = 1'b0;
      tick();
      strobes += int'(bus.ce_out);
      bus.step = 1'b1;
      tick();
      strobes += int'(bus.ce_out);
      total++;
      if (bus.ce_out !== 1'b1) $display("FAIL step_second got %0d exp 1", bus.ce_out);
      else passed++;
      bus.step = 1'b0;
      tick();
      strobes += int'(bus.ce_out);
      total++;
      if (strobes != 2) $display("FAIL step_count got %0d exp 2", strobes);
      else passed++;
      total++;
      if (bus.phase !== 24'd4) $display("FAIL step_phase got %0d exp 4", bus.phase);
      else passed++;
   endtask

   // div_d=0 strobes every running cycle; load coincident with a step edge.
   task automatic test_div_zero();
      bus.div_ld = 1'b1;
      bus.div_d  = 24'd0;
      tick();
      bus.div_ld = 1'b0;
      bus.run    = 1'b1;
      tick();
      total++;
      if (bus.ce_out !== 1'b0 || bus.running !== 1'b1)
         $display("FAIL zero_start got ce=%0d running=%0d exp ce=0 running=1", bus.ce_out, bus.running);
      else passed++;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (bus.ce_out !== 1'b1 || bus.phase !== 24'd0)
            $display("FAIL zero_cont_%0d got ce=%0d phase=%0d exp ce=1 phase=0", i, bus.ce_out, bus.phase);
         else passed++;
      end
      bus.run = 1'b0;
      tick();
      bus.div_ld = 1'b1;
      bus.div_d  = 24'd3;
      bus.step   = 1'b1;
      tick();
      bus.div_ld = 1'b0;
      total++;
      if (bus.ce_out !== 1'b0 || bus.phase !== 24'd2)
         $display("FAIL ld_step got ce=%0d phase=%0d exp ce=0 phase=2", bus.ce_out, bus.phase);
      else passed++;
      tick();
      total++;
      if (bus.ce_out !== 1'b0) $display("FAIL ld_step_hold got %0d exp 0", bus.ce_out);
      else passed++;
      bus.step = 1'b0;
      tick();
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      total++;
      if (bus.ce_out !== 1'b1 || bus.phase !== 24'd2)
         $display("FAIL ld_step_div got ce=%0d phase=%0d exp ce=1 phase=2", bus.ce_out, bus.phase);
      else passed++;
   endtask

   // N=64 with fast=1: first period 64, then 4 (macro) or 64 (no macro).
   task automatic test_fast();
      int errs;
      bus.div_ld = 1'b1;
      bus.div_d  = 24'd64;
      tick();
      bus.div_ld = 1'b0;
      bus.run    = 1'b1;
      bus.fast   = 1'b1;
      tick();
      errs = 0;
      for (int i = 1; i <= 64; i++) begin
         tick();
         if (bus.ce_out !== (i == 64)) errs++;
      end
      total++;
      if (errs != 0) $display("FAIL fast_first_period got %0d bad cycles exp 0", errs);
      else passed++;
`ifdef CE_STROBE_FAST_EN
      for (int i = 1; i <= 12; i++) begin
         tick();
         total++;
         if (bus.ce_out !== ((i % 4) == 0))
            $display("FAIL fast_period_%0d got %0d exp %0d", i, bus.ce_out, ((i % 4) == 0));
         else passed++;
      end
`else
      errs = 0;
      for (int i = 1; i <= 64; i++) begin
         tick();
         if (bus.ce_out !== (i == 64)) errs++;
      end
      total++;
      if (errs != 0) $display("FAIL fast_ignored got %0d bad cycles exp 0", errs);
      else passed++;
`endif
      bus.fast = 1'b0;
   endtask

   // Reset mid-count while running restores defaults.
   task automatic test_reset_mid();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      bus.run = 1'b0;
      total++;
      if (bus.ce_out !== 1'b0 || bus.running !== 1'b0 || bus.phase !== 24'd11999999)
         $display("FAIL reset_mid got ce=%0d running=%0d phase=%0d exp 0 0 11999999",
                  bus.ce_out, bus.running, bus.phase);
      else passed++;
      // A step reloads with div-1, which exposes the restored ratio.
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      total++;
      if (bus.ce_out !== 1'b1 || bus.phase !== 24'd11999999)
         $display("FAIL reset_div got ce=%0d phase=%0d exp ce=1 phase=11999999", bus.ce_out, bus.phase);
      else passed++;
   endtask

   initial begin
      passed     = 0;
      total      = 0;
      rst        = 1'b1;
      bus.run    = 1'b0;
      bus.step   = 1'b0;
      bus.div_ld = 1'b0;
      bus.div_d  = '0;
      bus.fast   = 1'b0;
      test_reset();
      test_run_period();
      test_pause_resume();
      test_step();
      test_div_zero();
      test_fast();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
